eth_cfg_csr: RTL and testbench
==============================

# eth_cfg_csr

Multi-interface AXI4-Lite configuration and status register block for the UDP/IP stack. It provides per-interface local MAC, local IP, gateway IP, subnet mask and ARP-cache-clear controls for N_IFACES instances of the UDP stack. Each interface also gets saturating, clear-on-command event counters fed by the stack's single-cycle error/status strobes. It sits between the AXI slave port of the wrapper and the configuration/status pins of the UDP instances.

## Interface
- N_IFACES, 1, number of UDP stack instances served (1..8)
- N_EVT, 13, event strobes per interface (1..16)
- CNT_WIDTH, 16, event counter width (1..32)
- ID_WIDTH, 8, AXI ID width (≥1)
- ADDR_WIDTH, 12, AXI address width; must be ≥ 7+clog2(N_IFACES)
- DEFAULT_MAC, 48'h02_00_00_00_00_01, reset MAC of every interface
- DEFAULT_IP / DEFAULT_GW / DEFAULT_MASK, 32'hC0A8_0001 / 32'hC0A8_00FE / 32'hFFFF_FF00, reset values
- clk  in  1  clock
- arst  in  1  asynchronous reset, active-high
- i_awvalid/o_awready, i_awid[ID_WIDTH], i_awaddr[ADDR_WIDTH]  AXI write address
- i_wvalid/o_wready, i_wdata[32], i_wstrb[4]  AXI write data
- o_bvalid/i_bready, o_bid[ID_WIDTH], o_bresp[2]  AXI write response
- i_arvalid/o_arready, i_arid[ID_WIDTH], i_araddr[ADDR_WIDTH]  AXI read address
- o_rvalid/i_rready, o_rid[ID_WIDTH], o_rdata[32], o_rresp[2]  AXI read data
- o_local_mac  out  48*N_IFACES  per-interface MAC (interface i at [48i+:48])
- o_local_ip, o_gateway_ip, o_subnet_mask  out  32*N_IFACES each  per-interface config
- o_clear_arp  out  N_IFACES  one-cycle ARP-cache-clear pulse
- i_evt  in  N_EVT*N_IFACES  single-cycle event strobes (interface i at [N_EVT*i+:N_EVT])

## Operation
- Address decoding: interface index = addr[ADDR_WIDTH-1:7]. Offset = addr[6:0]. addr[1:0] ignored.
- Per-interface map:
  - 0x00 MAC_LO = mac[31:0], RW
  - 0x04 MAC_HI = mac[47:32] in [15:0], RW; upper bits read 0
  - 0x08 IP, RW
  - 0x0C GW, RW
  - 0x10 MASK, RW
  - 0x14 CTRL, write-1 action, reads 0. bit0 = CLEAR_ARP; bit1 = CNT_CLR, which zeroes all counters of that interface
  - 0x40+4k EVT_CNT[k], k<N_EVT, RO, zero-extended to 32 bits. Writes to it are ignored and return OKAY.
- Responses:
  - Index ≥ N_IFACES: DECERR (2'b11).
  - Unmapped offset inside a valid interface: SLVERR (2'b10).
  - On any error response, no state changes and rdata=0.
  - Otherwise OKAY.
- wstrb: byte-lane enables on RW registers. CTRL bits act only if wstrb[0] is set.
- Counters: +1 per cycle in which the strobe is high. They saturate at all-ones and do not wrap.
- Read and write channels are fully independent and may complete in the same cycle.

## Timing
- Reset: all configuration registers take their DEFAULT_* values. Counters=0. All ready/valid outputs, o_clear_arp, bresp, rresp, rdata, bid and rid = 0.
- Write:
  - o_awready=o_wready=1 for exactly one cycle when i_awvalid&i_wvalid are both high and no B response is pending. AW and W are accepted together; neither is accepted alone.
  - The register update and o_bvalid happen the cycle after acceptance. bid echoes awid.
  - o_bvalid is held until i_bready. No new write is accepted while bvalid=1.
- Read:
  - o_arready=1 when no R response is pending. rdata is registered; o_rvalid is asserted the cycle after acceptance and held until i_rready.
  - rdata/rid/rresp are stable while rvalid=1. At most one read is outstanding.
- CLEAR_ARP: o_clear_arp[i] is high for exactly one cycle, in the same cycle bvalid rises.
- Event and CNT_CLR in the same cycle: the clear wins, and the counter becomes 0, not 1.
- A counter read in the same cycle as an increment returns the pre-increment value.
- arst mid-transaction: the pending response is dropped and all outputs return to their reset values immediately.

## Test plan
- Reset defaults (N_IFACES=2): read 0x08 -> rdata=C0A80001, OKAY. Read 0x84 -> 0x0201... MAC_HI=0x0200, OKAY. o_local_mac[95:48]=02_00_00_00_00_01.
- Byte-strobe write: write 0x8C data 0xDEADBEEF, wstrb=4'b0101 -> o_gateway_ip[63:32]=0xC0AD00EF. bresp=OKAY with bid echoed. bvalid holds under bready=0 for 5 cycles.
- Errors: write 0x100 with N_IFACES=2 -> DECERR and no state change. Read 0x18 -> SLVERR, rdata=0.
- Counters with CNT_WIDTH=4: pulse i_evt[0] 20 times -> EVT_CNT0 reads 0xF. Assert i_evt[0] in the same cycle as the CNT_CLR write -> counter reads 0.
- CLEAR_ARP: write 0x94=0x1 -> o_clear_arp=2'b10 for one cycle, coincident with bvalid. A following read of 0x94 returns 0.
- Concurrency: AW/W and AR issued in the same cycle, with arst asserted while bvalid is pending -> both channels complete independently. After reset, bvalid=0 and registers are at their defaults.

Source files
------------

// File: rtl/eth_cfg_csr.sv
// eth_cfg_csr: AXI4-Lite configuration/status block for N_IFACES UDP stack
// instances. Each interface has MAC/IP/gateway/mask registers, an ARP-clear
// pulse, and saturating event counters driven by single-cycle strobes.
module eth_cfg_csr #(
   parameter int          N_IFACES     = 1,
   parameter int          N_EVT        = 13,
   parameter int          CNT_WIDTH    = 16,
   parameter int          ID_WIDTH     = 8,
   parameter int          ADDR_WIDTH   = 12,
   parameter logic [47:0] DEFAULT_MAC  = 48'h02_00_00_00_00_01,
   parameter logic [31:0] DEFAULT_IP   = 32'hC0A8_0001,
   parameter logic [31:0] DEFAULT_GW   = 32'hC0A8_00FE,
   parameter logic [31:0] DEFAULT_MASK = 32'hFFFF_FF00
) (
   input  logic                      clk,
   input  logic                      arst,
   input  logic                      i_awvalid,
   output logic                      o_awready,
   input  logic [ID_WIDTH-1:0]       i_awid,
   input  logic [ADDR_WIDTH-1:0]     i_awaddr,
   input  logic                      i_wvalid,
   output logic                      o_wready,
   input  logic [31:0]               i_wdata,
   input  logic [3:0]                i_wstrb,
   output logic                      o_bvalid,
   input  logic                      i_bready,
   output logic [ID_WIDTH-1:0]       o_bid,
   output logic [1:0]                o_bresp,
   input  logic                      i_arvalid,
   output logic                      o_arready,
   input  logic [ID_WIDTH-1:0]       i_arid,
   input  logic [ADDR_WIDTH-1:0]     i_araddr,
   output logic                      o_rvalid,
   input  logic                      i_rready,
   output logic [ID_WIDTH-1:0]       o_rid,
   output logic [31:0]               o_rdata,
   output logic [1:0]                o_rresp,
   output logic [48*N_IFACES-1:0]    o_local_mac,
   output logic [32*N_IFACES-1:0]    o_local_ip,
   output logic [32*N_IFACES-1:0]    o_gateway_ip,
   output logic [32*N_IFACES-1:0]    o_subnet_mask,
   output logic [N_IFACES-1:0]       o_clear_arp,
   input  logic [N_EVT*N_IFACES-1:0] i_evt
);

   localparam int             IDXW    = ADDR_WIDTH - 7;
   localparam logic [IDXW:0]  N_IF_L  = (IDXW+1)'(N_IFACES);
   localparam logic [5:0]     EVT_END = 6'(16 + N_EVT);
   localparam logic [1:0]     OKAY    = 2'b00;
   localparam logic [1:0]     SLVERR  = 2'b10;
   localparam logic [1:0]     DECERR  = 2'b11;

   // a = addr[ADDR_WIDTH-1:2]: interface index above bit 4, word offset in [4:0]
   function automatic logic [1:0] decode_resp(input logic [ADDR_WIDTH-3:0] a);
      logic [1:0] resp;
      resp = SLVERR;
      if ({1'b0, a[ADDR_WIDTH-3:5]} >= N_IF_L)
         resp = DECERR;
      else if (a[4:0] < 5'd6)
         resp = OKAY;
      else if ({1'b0, a[4:0]} >= 6'd16 && {1'b0, a[4:0]} < EVT_END)
         resp = OKAY;
      return resp;
   endfunction

   logic                r_live;
   logic                r_bvalid;
   logic [1:0]          r_bresp;
   logic [ID_WIDTH-1:0] r_bid;
   logic                r_rvalid;
   logic [1:0]          r_rresp;
   logic [ID_WIDTH-1:0] r_rid;
   logic [31:0]         r_rdata;

   logic [IDXW-1:0]     w_wr_idx;
   logic [IDXW-1:0]     w_rd_idx;
   logic [4:0]          w_wr_word;
   logic [4:0]          w_rd_word;
   logic [1:0]          w_wr_resp;
   logic [1:0]          w_rd_resp;
   logic                w_wr_fire;
   logic                w_wr_ok;
   logic                w_rd_fire;
   logic [31:0]         w_rd_data;
   logic [31:0]         w_if_rdata [N_IFACES];
   logic                w_unused;

   assign w_wr_idx  = i_awaddr[ADDR_WIDTH-1:7];
   assign w_rd_idx  = i_araddr[ADDR_WIDTH-1:7];
   assign w_wr_word = i_awaddr[6:2];
   assign w_rd_word = i_araddr[6:2];
   assign w_wr_resp = decode_resp(i_awaddr[ADDR_WIDTH-1:2]);
   assign w_rd_resp = decode_resp(i_araddr[ADDR_WIDTH-1:2]);
   assign w_unused  = &{1'b0, i_awaddr[1:0], i_araddr[1:0]};

   // AW and W are only taken together, and never while a B response waits
   assign o_awready = r_live & ~r_bvalid & i_awvalid & i_wvalid;
   assign o_wready  = o_awready;
   assign w_wr_fire = o_awready;
   assign w_wr_ok   = w_wr_fire && (w_wr_resp == OKAY);
   assign o_arready = r_live & ~r_rvalid;
   assign w_rd_fire = o_arready & i_arvalid;

   assign o_bvalid = r_bvalid;
   assign o_bresp  = r_bresp;
   assign o_bid    = r_bid;
   assign o_rvalid = r_rvalid;
   assign o_rresp  = r_rresp;
   assign o_rid    = r_rid;
   assign o_rdata  = r_rdata;

   // Holds both readies low until the first clock after reset release
   always_ff @(posedge clk or posedge arst) begin
      if (arst) r_live <= 1'b0;
      else      r_live <= 1'b1;
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_IFACES; gi++) begin : g_if
         logic [47:0]          r_mac;
         logic [31:0]          r_ip;
         logic [31:0]          r_gw;
         logic [31:0]          r_mask;
         logic                 r_clr_arp;
         logic [CNT_WIDTH-1:0] r_cnt [N_EVT];
         logic                 w_sel;
         logic                 w_ctrl;
         logic                 w_cnt_clr;
         logic [31:0]          w_rdata;

         assign w_sel     = w_wr_ok && (w_wr_idx == IDXW'(gi));
         assign w_ctrl    = w_sel && (w_wr_word == 5'd5) && i_wstrb[0];
         assign w_cnt_clr = w_ctrl && i_wdata[1];

         // Byte-lane writes into the configuration registers
         always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
               r_mac  <= DEFAULT_MAC;
               r_ip   <= DEFAULT_IP;
               r_gw   <= DEFAULT_GW;
               r_mask <= DEFAULT_MASK;
            end else if (w_sel) begin
               for (int b = 0; b < 4; b++) begin
                  if (i_wstrb[b]) begin
                     case (w_wr_word)
                        5'd0: r_mac[8*b +: 8] <= i_wdata[8*b +: 8];
                        5'd1: if (b < 2) r_mac[32+8*b +: 8] <= i_wdata[8*b +: 8];
                        5'd2: r_ip[8*b +: 8]   <= i_wdata[8*b +: 8];
                        5'd3: r_gw[8*b +: 8]   <= i_wdata[8*b +: 8];
                        5'd4: r_mask[8*b +: 8] <= i_wdata[8*b +: 8];
                        default: ;
                     endcase
                  end
               end
            end
         end

         // One-cycle ARP-clear pulse, aligned with the rise of bvalid
         always_ff @(posedge clk or posedge arst) begin
            if (arst) r_clr_arp <= 1'b0;
            else      r_clr_arp <= w_ctrl & i_wdata[0];
         end

         // Saturating event counters; a same-cycle clear beats an increment
         always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
               for (int k = 0; k < N_EVT; k++) r_cnt[k] <= '0;
            end else begin
               for (int k = 0; k < N_EVT; k++) begin
                  if (w_cnt_clr)
                     r_cnt[k] <= '0;
                  else if (i_evt[N_EVT*gi + k] && (r_cnt[k] != '1))
                     r_cnt[k] <= r_cnt[k] + CNT_WIDTH'(1);
               end
            end
         end

         // Per-interface read word selection
         always_comb begin
            w_rdata = '0;
            case (w_rd_word)
               5'd0: w_rdata = r_mac[31:0];
               5'd1: w_rdata = {16'h0000, r_mac[47:32]};
               5'd2: w_rdata = r_ip;
               5'd3: w_rdata = r_gw;
               5'd4: w_rdata = r_mask;
               default: ;
            endcase
            for (int k = 0; k < N_EVT; k++)
               if (w_rd_word == 5'(16 + k)) w_rdata = 32'(r_cnt[k]);
         end

         assign w_if_rdata[gi]          = w_rdata;
         assign o_local_mac[48*gi +: 48]   = r_mac;
         assign o_local_ip[32*gi +: 32]    = r_ip;
         assign o_gateway_ip[32*gi +: 32]  = r_gw;
         assign o_subnet_mask[32*gi +: 32] = r_mask;
         assign o_clear_arp[gi]            = r_clr_arp;
      end
   endgenerate

   // Interface select for the read path
   always_comb begin
      w_rd_data = '0;
      for (int i = 0; i < N_IFACES; i++)
         if (w_rd_idx == IDXW'(i)) w_rd_data = w_if_rdata[i];
   end

   // Write response channel
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_bvalid <= 1'b0;
         r_bresp  <= 2'b00;
         r_bid    <= '0;
      end else if (w_wr_fire) begin
         r_bvalid <= 1'b1;
         r_bresp  <= w_wr_resp;
         r_bid    <= i_awid;
      end else if (i_bready) begin
         r_bvalid <= 1'b0;
      end
   end

   // Read data channel; payload is frozen while rvalid is high
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_rvalid <= 1'b0;
         r_rresp  <= 2'b00;
         r_rid    <= '0;
         r_rdata  <= '0;
      end else if (w_rd_fire) begin
         r_rvalid <= 1'b1;
         r_rresp  <= w_rd_resp;
         r_rid    <= i_arid;
         r_rdata  <= (w_rd_resp == OKAY) ? w_rd_data : 32'h0;
      end else if (i_rready) begin
         r_rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_eth_cfg_csr.sv
// Randomized testbench for eth_cfg_csr with a behavioural register model.
module tb_eth_cfg_csr;

   localparam int N_IF = 2;
   localparam int N_EVT = 13;
   localparam int CW = 4;
   localparam int IDW = 8;
   localparam int AW = 12;
   localparam int EW = N_IF * N_EVT;
   localparam int CMAX = (1 << CW) - 1;

   logic                clk = 1'b0;
   logic                arst = 1'b0;
   logic                i_awvalid = 0, i_wvalid = 0, i_bready = 0, i_arvalid = 0, i_rready = 0;
   logic [IDW-1:0]      i_awid = '0, i_arid = '0;
   logic [AW-1:0]       i_awaddr = '0, i_araddr = '0;
   logic [31:0]         i_wdata = '0;
   logic [3:0]          i_wstrb = '0;
   logic [EW-1:0]       i_evt = '0;
   logic                o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
   logic [IDW-1:0]      o_bid, o_rid;
   logic [1:0]          o_bresp, o_rresp;
   logic [31:0]         o_rdata;
   logic [48*N_IF-1:0]  o_local_mac;
   logic [32*N_IF-1:0]  o_local_ip, o_gateway_ip, o_subnet_mask;
   logic [N_IF-1:0]     o_clear_arp;

   eth_cfg_csr #(
      .N_IFACES(N_IF), .N_EVT(N_EVT), .CNT_WIDTH(CW), .ID_WIDTH(IDW), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .arst(arst),
      .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awid(i_awid), .i_awaddr(i_awaddr),
      .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
      .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bid(o_bid), .o_bresp(o_bresp),
      .i_arvalid(i_arvalid), .o_arready(o_arready), .i_arid(i_arid), .i_araddr(i_araddr),
      .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp),
      .o_local_mac(o_local_mac), .o_local_ip(o_local_ip), .o_gateway_ip(o_gateway_ip),
      .o_subnet_mask(o_subnet_mask), .o_clear_arp(o_clear_arp), .i_evt(i_evt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   bit evt_on = 0;

   // Reference model state
   logic [47:0] m_mac  [N_IF];
   logic [31:0] m_ip   [N_IF];
   logic [31:0] m_gw   [N_IF];
   logic [31:0] m_mask [N_IF];
   int          m_cnt  [N_IF][N_EVT];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_IF; i++) begin
         m_mac[i]  = 48'h02_00_00_00_00_01;
         m_ip[i]   = 32'hC0A8_0001;
         m_gw[i]   = 32'hC0A8_00FE;
         m_mask[i] = 32'hFFFF_FF00;
         for (int k = 0; k < N_EVT; k++) m_cnt[i][k] = 0;
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic void model_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] r);
      int idx;
      int off;
      idx = int'(a[AW-1:7]);
      off = int'(a[6:2]) * 4;
      d = 32'h0;
      r = 2'b00;
      if (idx >= N_IF) begin
         r = 2'b11;
         return;
      end
      case (off)
         'h00: d = m_mac[idx][31:0];
         'h04: d = {16'h0, m_mac[idx][47:32]};
         'h08: d = m_ip[idx];
         'h0C: d = m_gw[idx];
         'h10: d = m_mask[idx];
         'h14: d = 32'h0;
         default: begin
            if (off >= 'h40 && (off - 'h40) / 4 < N_EVT) d = 32'(m_cnt[idx][(off - 'h40) / 4]);
            else r = 2'b10;
         end
      endcase
   endfunction

   function automatic void model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                                       output logic [1:0] r, output logic [N_IF-1:0] clr);
      int idx;
      int off;
      logic [31:0] t;
      idx = int'(a[AW-1:7]);
      off = int'(a[6:2]) * 4;
      r = 2'b00;
      clr = '0;
      if (idx >= N_IF) begin
         r = 2'b11;
         return;
      end
      case (off)
         'h00: m_mac[idx][31:0] = merge(m_mac[idx][31:0], d, s);
         'h04: begin
            t = merge({16'h0, m_mac[idx][47:32]}, d, s);
            m_mac[idx][47:32] = t[15:0];
         end
         'h08: m_ip[idx]   = merge(m_ip[idx], d, s);
         'h0C: m_gw[idx]   = merge(m_gw[idx], d, s);
         'h10: m_mask[idx] = merge(m_mask[idx], d, s);
         'h14: if (s[0]) begin
            if (d[0]) clr[idx] = 1'b1;
            if (d[1]) for (int k = 0; k < N_EVT; k++) m_cnt[idx][k] = 0;
         end
         default: if (!(off >= 'h40 && (off - 'h40) / 4 < N_EVT)) r = 2'b10;
      endcase
   endfunction

   // One clock: model counts the strobes that were present at this edge
   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < N_IF; i++)
         for (int k = 0; k < N_EVT; k++)
            if (i_evt[i*N_EVT + k] && m_cnt[i][k] < CMAX) m_cnt[i][k]++;
      #1;
      i_evt = evt_on ? EW'($urandom & $urandom & $urandom) : '0;
   endtask

   task automatic check_cfg();
      for (int i = 0; i < N_IF; i++) begin
         chk("local_mac", o_local_mac[48*i +: 48], m_mac[i]);
         chk("local_ip", o_local_ip[32*i +: 32], m_ip[i]);
         chk("gateway_ip", o_gateway_ip[32*i +: 32], m_gw[i]);
         chk("subnet_mask", o_subnet_mask[32*i +: 32], m_mask[i]);
      end
   endtask

   task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [IDW-1:0] id, input int hold);
      logic [1:0] r;
      logic [N_IF-1:0] clr;
      i_awvalid = 1; i_wvalid = 1; i_awaddr = a; i_wdata = d; i_wstrb = s; i_awid = id;
      #1;
      chk("awready", o_awready, 1'b1);
      chk("wready", o_wready, 1'b1);
      tick();
      i_awvalid = 0; i_wvalid = 0;
      model_write(a, d, s, r, clr);
      chk("bvalid_rise", o_bvalid, 1'b1);
      chk("bresp", o_bresp, r);
      chk("bid", o_bid, id);
      chk("clear_arp_pulse", o_clear_arp, clr);
      check_cfg();
      for (int h = 0; h < hold; h++) begin
         if (h == 0) begin
            i_awvalid = 1; i_wvalid = 1;
            #1;
            chk("awready_blocked", o_awready, 1'b0);
            i_awvalid = 0; i_wvalid = 0;
         end
         tick();
         chk("bvalid_hold", o_bvalid, 1'b1);
         chk("clear_arp_done", o_clear_arp, '0);
      end
      i_bready = 1;
      tick();
      i_bready = 0;
      chk("bvalid_fall", o_bvalid, 1'b0);
      chk("clear_arp_idle", o_clear_arp, '0);
      $display("WR addr=%03h data=%08h strb=%b id=%02h resp=%0d", a, d, s, id, r);
   endtask

   task automatic axi_read(input logic [AW-1:0] a, input logic [IDW-1:0] id, input int hold);
      logic [31:0] d;
      logic [1:0] r;
      i_arvalid = 1; i_araddr = a; i_arid = id;
      #1;
      chk("arready", o_arready, 1'b1);
      model_read(a, d, r);
      tick();
      i_arvalid = 0;
      chk("rvalid_rise", o_rvalid, 1'b1);
      chk("rdata", o_rdata, d);
      chk("rresp", o_rresp, r);
      chk("rid", o_rid, id);
      for (int h = 0; h < hold; h++) begin
         tick();
         chk("rvalid_hold", o_rvalid, 1'b1);
         chk("rdata_stable", o_rdata, d);
         chk("arready_blocked", o_arready, 1'b0);
      end
      i_rready = 1;
      tick();
      i_rready = 0;
      chk("rvalid_fall", o_rvalid, 1'b0);
      $display("RD addr=%03h id=%02h data=%08h resp=%0d", a, id, d, r);
   endtask

   task automatic do_reset();
      arst = 1;
      i_awvalid = 1; i_wvalid = 1;
      #2;
      chk("rst_awready", o_awready, 1'b0);
      chk("rst_arready", o_arready, 1'b0);
      chk("rst_bvalid", o_bvalid, 1'b0);
      chk("rst_rvalid", o_rvalid, 1'b0);
      chk("rst_bresp", o_bresp, 2'b00);
      chk("rst_rresp", o_rresp, 2'b00);
      chk("rst_rdata", o_rdata, 32'h0);
      chk("rst_bid", o_bid, '0);
      chk("rst_rid", o_rid, '0);
      chk("rst_clear_arp", o_clear_arp, '0);
      i_awvalid = 0; i_wvalid = 0; i_arvalid = 0; i_bready = 0; i_rready = 0;
      model_reset();
      check_cfg();
      @(negedge clk);
      arst = 0;
      tick();
      tick();
      $display("RESET released");
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_rd;
      logic [1:0]  exp_rr;
      logic [1:0]  wr_r;
      logic [N_IF-1:0] wr_clr;
      #1;
      do_reset();

      // Reset defaults
      axi_read(12'h008, 8'h01, 1);
      axi_read(12'h084, 8'h02, 0);
      chk("mac1_default", o_local_mac[95:48], 48'h02_00_00_00_00_01);

      // Byte-strobe write with a long bready stall
      axi_write(12'h08C, 32'hDEADBEEF, 4'b0101, 8'hA5, 5);
      chk("gw1_strobe", o_gateway_ip[63:32], 32'hC0AD_00EF);
      axi_write(12'h004, 32'hFFFF_1234, 4'b1111, 8'h10, 0);
      axi_read(12'h004, 8'h11, 0);

      // Error responses
      axi_write(12'h100, 32'h1234_5678, 4'b1111, 8'h33, 1);
      axi_read(12'h018, 8'h44, 2);
      axi_write(12'h0FC, 32'hFFFF_FFFF, 4'b1111, 8'h45, 0);
      axi_write(12'h040, 32'hFFFF_FFFF, 4'b1111, 8'h46, 0);

      // Counter saturation and clear-vs-increment priority
      evt_on = 0;
      axi_write(12'h014, 32'h2, 4'b0001, 8'h50, 0);
      for (int n = 0; n < 20; n++) begin
         i_evt = EW'(1);
         tick();
         tick();
      end
      axi_read(12'h040, 8'h51, 0);
      i_evt = EW'(1) | (EW'(1) << N_EVT);
      axi_write(12'h014, 32'h2, 4'b0001, 8'h52, 0);
      axi_read(12'h040, 8'h53, 0);
      axi_read(12'h0C0, 8'h54, 0);
      // Counter read coinciding with an increment returns the old value
      i_evt = EW'(1) << (N_EVT + 2);
      axi_read(12'h0C8, 8'h55, 0);
      axi_read(12'h0C8, 8'h56, 0);

      // ARP clear pulse on interface 1
      axi_write(12'h094, 32'h1, 4'b0001, 8'h60, 2);
      axi_read(12'h094, 8'h61, 0);
      axi_write(12'h014, 32'h1, 4'b0010, 8'h62, 0);

      // Same-cycle write and read, then reset while responses are pending
      i_awvalid = 1; i_wvalid = 1; i_awaddr = 12'h008; i_wdata = 32'h0A0B_0C0D; i_wstrb = 4'hF; i_awid = 8'h71;
      i_arvalid = 1; i_araddr = 12'h008; i_arid = 8'h72;
      #1;
      chk("cc_awready", o_awready, 1'b1);
      chk("cc_arready", o_arready, 1'b1);
      model_read(12'h008, exp_rd, exp_rr);
      tick();
      i_awvalid = 0; i_wvalid = 0; i_arvalid = 0;
      model_write(12'h008, 32'h0A0B_0C0D, 4'hF, wr_r, wr_clr);
      chk("cc_bvalid", o_bvalid, 1'b1);
      chk("cc_bresp", o_bresp, wr_r);
      chk("cc_rvalid", o_rvalid, 1'b1);
      chk("cc_rdata", o_rdata, exp_rd);
      chk("cc_rid", o_rid, 8'h72);
      check_cfg();
      $display("WR+RD addr=008 concurrent");
      tick();
      do_reset();
      axi_read(12'h008, 8'h73, 0);

      // Randomized traffic
      evt_on = 1;
      for (int t = 0; t < 200; t++) begin
         int sel;
         int idx;
         int word;
         logic [AW-1:0] a;
         sel = $urandom_range(0, 9);
         idx = (sel < 4) ? 0 : (sel < 8) ? 1 : (sel == 8) ? 2 : 31;
         word = $urandom_range(0, 1) ? $urandom_range(0, 5) : $urandom_range(0, 31);
         a = {5'(idx), 5'(word), 2'($urandom)};
         if ($urandom_range(0, 1))
            axi_write(a, $urandom, 4'($urandom), 8'($urandom), $urandom_range(0, 3));
         else
            axi_read(a, 8'($urandom), $urandom_range(0, 3));
      end
      evt_on = 0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
